// File: rtl/video_pkg.sv
// video_pkg: timing description, lock states and colour-bar lookup shared by the
// video output path.
package video_pkg;

    typedef struct packed {
        int hdisp, hfp, hpulse, hbp;
        int vdisp, vfp, vpulse, vbp;
    } video_timing_t;

    localparam video_timing_t DEFAULT_TIMING = '{800, 40, 48, 40, 480, 13, 3, 29};

    typedef enum logic [1:0] {HUNT, ARMED, RUN} lock_state_t;

    function automatic int htotal(input video_timing_t t);
        return t.hdisp + t.hfp + t.hpulse + t.hbp;
    endfunction

    function automatic int vtotal(input video_timing_t t);
        return t.vdisp + t.vfp + t.vpulse + t.vbp;
    endfunction

    function automatic int hblank(input video_timing_t t);
        return t.hfp + t.hpulse + t.hbp;
    endfunction

    function automatic int vblank(input video_timing_t t);
        return t.vfp + t.vpulse + t.vbp;
    endfunction

    // {R,G,B} on/off for white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        return {~idx[1], ~idx[2], ~idx[0]};
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// video_timing_cnt: free-running raster counters with active, sync and frame
// markers decoded from the current count.
module video_timing_cnt
    import video_pkg::*;
#(
    parameter video_timing_t T = DEFAULT_TIMING,
    parameter logic SYNC_POL = 1'b0,
    localparam int HT = htotal(T),
    localparam int VT = vtotal(T),
    localparam int HW = $clog2(HT),
    localparam int VW = $clog2(VT)
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hs,
    output logic          vs,
    output logic          frame_start,
    output logic          frame_end
);

    logic line_end, last_line;

    assign line_end    = h_cnt == HW'(HT - 1);
    assign last_line   = v_cnt == VW'(VT - 1);
    assign frame_end   = line_end & last_line;
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign active      = (h_cnt >= HW'(hblank(T))) && (v_cnt >= VW'(vblank(T)));
    assign hs = (h_cnt >= HW'(T.hfp) && h_cnt < HW'(T.hfp + T.hpulse)) ? SYNC_POL : ~SYNC_POL;
    assign vs = (v_cnt >= VW'(T.vfp) && v_cnt < VW'(T.vfp + T.vpulse)) ? SYNC_POL : ~SYNC_POL;

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + 1'b1;
            if (line_end) v_cnt <= last_line ? '0 : v_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/video_stream_out.sv
// video_stream_out: raster timing generator that locks a valid/ready pixel stream
// to the frame using its start-of-frame marker, with a colour-bar fallback.
module video_stream_out
    import video_pkg::*;
#(
    parameter int            HDISP    = 800,
    parameter int            VDISP    = 480,
    parameter int            HFP      = 40,
    parameter int            HPULSE   = 48,
    parameter int            HBP      = 40,
    parameter int            VFP      = 13,
    parameter int            VPULSE   = 3,
    parameter int            VBP      = 29,
    parameter logic          SYNC_POL = 1'b0,
    parameter int            CW       = 8,
    parameter logic [3*CW-1:0] FILL_RGB = '0
) (
    input  logic            pixel_clk,
    input  logic            pixel_rst_n,
    input  logic            enable,
    input  logic            mode,
    input  logic            clr_status,
    input  logic [3*CW-1:0] pix_data,
    input  logic            pix_sof,
    input  logic            pix_valid,
    output logic            pix_ready,
    output logic            vid_hs,
    output logic            vid_vs,
    output logic            vid_blank,
    output logic [3*CW-1:0] vid_rgb,
    output logic            frame_start,
    output logic            locked,
    output logic            underflow,
    output logic            sof_err
);

    localparam video_timing_t T = '{hdisp: HDISP, hfp: HFP, hpulse: HPULSE, hbp: HBP,
                                    vdisp: VDISP, vfp: VFP, vpulse: VPULSE, vbp: VBP};
    localparam int HW = $clog2(htotal(T));
    localparam int VW = $clog2(vtotal(T));

    logic [HW-1:0] h_cnt, x;
    logic [VW-1:0] v_cnt;
    logic [HW+2:0] x8;
    logic [2:0]    bar;
    logic          active, hs, vs, fstart, frame_end, first, stream_en, sof_ok;
    lock_state_t   state;

    video_timing_cnt #(.T(T), .SYNC_POL(SYNC_POL)) u_timing (
        .pixel_clk   (pixel_clk),
        .pixel_rst_n (pixel_rst_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .hs          (hs),
        .vs          (vs),
        .frame_start (fstart),
        .frame_end   (frame_end)
    );

    assign x         = h_cnt - HW'(hblank(T));
    assign x8        = {x, 3'b000};
    assign bar       = bar_color(3'(x8 / (HW+3)'(HDISP)));
    assign first     = (h_cnt == HW'(hblank(T))) && (v_cnt == VW'(vblank(T)));
    assign stream_en = enable & ~mode;
    // SOF must coincide with the first active pixel; a mismatched pixel is left in the FIFO
    assign sof_ok    = pix_sof == first;
    assign pix_ready = pixel_rst_n & stream_en &
                       ((state == HUNT) ? ~pix_sof : (state == RUN) & active & sof_ok);

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state       <= HUNT;
            vid_hs      <= ~SYNC_POL;
            vid_vs      <= ~SYNC_POL;
            vid_blank   <= 1'b0;
            vid_rgb     <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            underflow   <= 1'b0;
            sof_err     <= 1'b0;
        end else begin
            vid_hs      <= hs;
            vid_vs      <= vs;
            frame_start <= fstart;
            vid_blank   <= enable & active;
            vid_rgb     <= !(enable && active) ? '0 :
                           mode ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}} :
                           (state == RUN && pix_valid && sof_ok) ? pix_data : FILL_RGB;
            underflow   <= underflow & ~clr_status;
            sof_err     <= sof_err & ~clr_status;
            if (!stream_en) begin
                state  <= HUNT;
                locked <= 1'b0;
            end else begin
                case (state)
                    HUNT:  if (pix_valid && pix_sof) state <= ARMED;
                    ARMED: if (frame_end) begin
                        state  <= RUN;
                        locked <= 1'b1;
                    end
                    RUN: if (active && !pix_valid) begin
                        underflow <= 1'b1;
                        state     <= HUNT;
                        locked    <= 1'b0;
                    end else if (active && !sof_ok) begin
                        sof_err <= 1'b1;
                        state   <= first ? HUNT : ARMED;
                        locked  <= 1'b0;
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_stream_out.sv
// tb_video_stream_out: small-raster bench with a cycle model feeding an output
// scoreboard, plus directed lock, underflow, SOF-error and reset scenarios.
module tb_video_stream_out;

    localparam logic [23:0] FILL = 24'h123456;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct packed {
        logic hs, vs, blank;
        logic [23:0] rgb;
        logic fs, lk, uf, se;
    } out_t;

    logic pixel_clk = 0, pixel_rst_n = 0, enable = 0, mode = 0, clr_status = 0;
    logic pix_sof = 0, pix_valid = 0;
    logic [23:0] pix_data = '0;
    logic rdy0, hs0, vs0, blank0, fs0, lk0, uf0, se0;
    logic rdy1, hs1, vs1, blank1, fs1, lk1, uf1, se1;
    logic [23:0] rgb0, rgb1;

    out_t exp_q[$];
    logic [24:0] fifo[$];
    int vectors = 0, errors = 0;
    int mh, mv, ms;
    logic muf, mse;
    bit hold, last_took;

    always #5 pixel_clk = ~pixel_clk;

    video_stream_out #(.HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2), .VFP(1), .VPULSE(1),
                       .VBP(1), .SYNC_POL(1'b0), .CW(8), .FILL_RGB(FILL)) dut0 (
        .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .enable(enable), .mode(mode),
        .clr_status(clr_status), .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
        .pix_ready(rdy0), .vid_hs(hs0), .vid_vs(vs0), .vid_blank(blank0), .vid_rgb(rgb0),
        .frame_start(fs0), .locked(lk0), .underflow(uf0), .sof_err(se0));

    video_stream_out #(.HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2), .VFP(1), .VPULSE(1),
                       .VBP(1), .SYNC_POL(1'b1), .CW(8), .FILL_RGB(FILL)) dut1 (
        .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .enable(enable), .mode(mode),
        .clr_status(clr_status), .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
        .pix_ready(rdy1), .vid_hs(hs1), .vid_vs(vs1), .vid_blank(blank1), .vid_rgb(rgb1),
        .frame_start(fs1), .locked(lk1), .underflow(uf1), .sof_err(se1));

    task automatic model_reset();
        mh = 0; mv = 0; ms = 0; muf = 0; mse = 0;
        exp_q.delete();
    endtask

    task automatic drive();
        pix_valid = fifo.size() > 0 && !hold;
        {pix_sof, pix_data} = pix_valid ? fifo[0] : 25'h0;
    endtask

    // One pixel clock: predict, let the DUT clock, then compare its registered outputs.
    task automatic tick();
        bit act, first, en_s, rdy, v, s;
        int nx;
        out_t e, got;
        drive();
        #1;
        v = pix_valid; s = pix_sof;
        act = mh >= 6 && mv >= 3;
        first = act && mh == 6 && mv == 3;
        en_s = enable && !mode;
        rdy = en_s && (ms == 0 ? !s : ms == 2 ? (act && (s == first)) : 1'b0);
        if (v) begin
            vectors++;
            if (rdy0 !== rdy || rdy1 !== rdy) begin
                errors++;
                $display("FAIL pix_ready h=%0d v=%0d got %b/%b want %b", mh, mv, rdy0, rdy1, rdy);
            end
        end
        e.hs = !(mh >= 2 && mh < 4);
        e.vs = !(mv == 1);
        e.blank = enable && act;
        e.rgb = !e.blank ? 24'h0 : mode ? BARS[act ? mh - 6 : 0] :
                (ms == 2 && v && s == first) ? pix_data : FILL;
        e.fs = mh == 0 && mv == 0;
        e.uf = muf & !clr_status;
        e.se = mse & !clr_status;
        nx = ms;
        if (!en_s) nx = 0;
        else if (ms == 0) begin if (v && s) nx = 1; end
        else if (ms == 1) begin if (mh == 13 && mv == 6) nx = 2; end
        else if (act) begin
            if (!v) begin nx = 0; e.uf = 1; end
            else if (s != first) begin nx = first ? 0 : 1; e.se = 1; end
        end
        e.lk = nx == 2;
        exp_q.push_back(e);
        last_took = v && rdy;
        @(posedge pixel_clk);
        if (last_took) void'(fifo.pop_front());
        ms = nx; muf = e.uf; mse = e.se;
        mh = (mh == 13) ? 0 : mh + 1;
        if (mh == 0) mv = (mv == 6) ? 0 : mv + 1;
        @(negedge pixel_clk);
        e = exp_q.pop_front();
        got = {hs0, vs0, blank0, rgb0, fs0, lk0, uf0, se0};
        vectors++;
        if (got !== e) begin
            errors++;
            $display("FAIL outputs(pol0) got %h want %h", got, e);
        end
        got = {~hs1, ~vs1, blank1, rgb1, fs1, lk1, uf1, se1};
        vectors++;
        if (got !== e) begin
            errors++;
            $display("FAIL outputs(pol1) got %h want %h (sync inverted)", got, e);
        end
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        pixel_rst_n = 0;
        model_reset();
        repeat (2) @(negedge pixel_clk);
        pixel_rst_n = 1;
    endtask

    task automatic push_frame(input int f);
        for (int k = 0; k < 32; k++) fifo.push_back({k == 0, 8'(f + 1), 8'h00, 8'(k)});
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if ({hs0, vs0, blank0, rgb0, fs0, lk0, uf0, se0, rdy0} !== {2'b11, 1'b0, 24'h0, 5'b0} ||
            {hs1, vs1, blank1, rgb1, fs1, lk1, uf1, se1, rdy1} !== {2'b00, 1'b0, 24'h0, 5'b0}) begin
            errors++;
            $display("FAIL %s got %b%b%b %h %b%b%b%b%b / %b%b%b %h %b%b%b%b%b want 110 000000 00000 / 000 000000 00000",
                     tag, hs0, vs0, blank0, rgb0, fs0, lk0, uf0, se0, rdy0,
                     hs1, vs1, blank1, rgb1, fs1, lk1, uf1, se1, rdy1);
        end
    endtask

    task automatic test_reset();
        enable = 1; pix_valid = 1;
        @(negedge pixel_clk);
        check_reset_values("reset_state");
        pix_valid = 0;
    endtask

    task automatic test_bars();
        int hs_low = 0, last = -1, period = 0;
        do_reset();
        enable = 1; mode = 1;
        for (int i = 0; i < 196; i++) begin
            tick();
            if (hs0 == 0) hs_low++;
            if (fs0) begin
                if (last >= 0) period = i - last;
                last = i;
            end
        end
        vectors++;
        if (hs_low != 28) begin errors++; $display("FAIL hs_low_cycles got %0d want 28", hs_low); end
        vectors++;
        if (period != 98) begin errors++; $display("FAIL frame_period got %0d want 98", period); end
        enable = 0;
        repeat (20) tick();
        enable = 1;
        repeat (10) tick();
    endtask

    task automatic test_lock();
        int drained = 0;
        do_reset();
        enable = 1; mode = 0;
        for (int k = 0; k < 5; k++) fifo.push_back({1'b0, 24'hA00000 + 24'(k)});
        for (int f = 0; f < 6; f++) push_frame(f);
        for (int i = 0; i <= 146; i++) begin
            tick();
            if (i < 98 && last_took) drained++;
            if (i == 96) begin
                vectors++;
                if (lk0 !== 1'b0) begin errors++; $display("FAIL locked_early got %b want 0", lk0); end
            end
            if (i == 97) begin
                vectors++;
                if (drained != 5) begin errors++; $display("FAIL drained got %0d want 5", drained); end
                vectors++;
                if (lk0 !== 1'b1) begin errors++; $display("FAIL locked_at_wrap got %b want 1", lk0); end
            end
        end
        vectors++;
        if ({blank0, rgb0} !== {1'b1, 24'h010000}) begin
            errors++;
            $display("FAIL first_pixel got %b %h want 1 010000", blank0, rgb0);
        end
    endtask

    task automatic test_underflow();
        int n = 0;
        while (!(mh == 9 && mv == 5) && n < 200) begin tick(); n++; end
        hold = 1; clr_status = 1;
        tick();
        clr_status = 0;
        vectors++;
        if ({rgb0, uf0, uf1, lk0} !== {FILL, 3'b110}) begin
            errors++;
            $display("FAIL underflow_pixel got %h %b%b%b want %h 110", rgb0, uf0, uf1, lk0, FILL);
        end
        repeat (2) tick();
        hold = 0;
        n = 0;
        while (!lk0 && n < 400) begin tick(); n++; end
        vectors++;
        if (lk0 !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", lk0); end
    endtask

    task automatic test_sof_err();
        int n = 0;
        logic [23:0] inj;
        while (!(mh == 9 && mv == 4) && n < 200) begin tick(); n++; end
        inj = fifo[0][23:0];
        fifo[0] = {1'b1, inj};
        tick();
        vectors++;
        if ({se0, lk0, rgb0} !== {2'b10, FILL}) begin
            errors++;
            $display("FAIL sof_err_pixel got %b%b %h want 10 %h", se0, lk0, rgb0, FILL);
        end
        n = 0;
        while (!(ms == 2 && mh == 6 && mv == 3) && n < 300) begin tick(); n++; end
        tick();
        vectors++;
        if ({lk0, rgb0} !== {1'b1, inj}) begin
            errors++;
            $display("FAIL resume_pixel got %b %h want 1 %h", lk0, rgb0, inj);
        end
    endtask

    task automatic test_clear();
        clr_status = 1;
        tick();
        clr_status = 0;
        vectors++;
        if ({uf0, se0} !== 2'b00) begin errors++; $display("FAIL clear_flags got %b%b want 00", uf0, se0); end
        repeat (5) tick();
    endtask

    task automatic test_reset_mid();
        enable = 1; mode = 0;
        fifo.push_front({1'b0, 24'hBEEF00});
        drive();
        #2 pixel_rst_n = 0;
        #1 check_reset_values("reset_mid_frame");
        model_reset();
        @(negedge pixel_clk);
        pixel_rst_n = 1;
        mode = 1;
        repeat (30) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_bars();
        test_lock();
        test_underflow();
        test_sof_err();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/video_stream_out.md
# video_stream_out

Parametrised successor of the fixed 800x480 display controller. It is a single-clock video timing generator with a streaming pixel sink. All porch, sync and colour-depth values are parameters, and sync polarity is selectable. It consumes pixels from an upstream FIFO through a valid/ready handshake with a start-of-frame marker and re-locks to the stream after underflow or misalignment. A built-in colour-bar mode supports bring-up without SDRAM. It sits between the pixel-domain side of the async FIFO and the HDMI transmitter pins.

## Interface
Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP / HPULSE / HBP, 40 / 48 / 40, horizontal front porch / sync / back porch in pixels
- VFP / VPULSE / VBP, 13 / 3 / 29, vertical front porch / sync / back porch in lines
- SYNC_POL, 0, sync pulse level (0 = active-low), shared by HS and VS
- CW, 8, bits per colour channel; RGB width = 3*CW
- FILL_RGB, 0, colour driven on underflow pixels

Ports:
- pixel_clk  in  1  pixel clock, sole clock
- pixel_rst_n  in  1  asynchronous, active-low reset
- enable  in  1  0 = output blanked, stream not consumed
- mode  in  1  0 = stream, 1 = colour bars
- clr_status  in  1  clears sticky flags
- pix_data  in  3*CW  pixel from FIFO head
- pix_sof  in  1  marks first pixel of a frame
- pix_valid  in  1  FIFO not empty
- pix_ready  out  1  pixel consumed this cycle when pix_valid & pix_ready
- vid_hs, vid_vs  out  1  sync outputs
- vid_blank  out  1  1 = active display pixel
- vid_rgb  out  3*CW  pixel colour
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0
- locked  out  1  FSM in RUN
- underflow, sof_err  out  1  sticky error flags

## Operation
- HTOTAL = HFP+HPULSE+HBP+HDISP; HBLANK = HTOTAL-HDISP. VTOTAL and VBLANK are defined the same way.
- h_cnt counts 0..HTOTAL-1 and wraps. v_cnt advances when h_cnt = HTOTAL-1 and wraps at VTOTAL-1.
- Line order: FP, sync, BP, active. Frame order is the same.
- active = (h_cnt >= HBLANK) & (v_cnt >= VBLANK); x = h_cnt-HBLANK; y = v_cnt-VBLANK.
- HS pulse: HFP <= h_cnt < HFP+HPULSE. VS pulse: VFP <= v_cnt < VFP+VPULSE. Outputs equal SYNC_POL inside the pulse and ~SYNC_POL outside.
- Counters run in every mode, including enable=0.

Lock FSM:
- HUNT: pix_ready = enable & ~mode & ~pix_sof. Non-SOF pixels are drained. pix_valid & pix_sof -> ARMED; the SOF pixel is not consumed.
- ARMED: pix_ready = 0. When h_cnt = HTOTAL-1 and v_cnt = VTOTAL-1 -> RUN.
- RUN: pix_ready = active.
  - Active with ~pix_valid: output FILL_RGB, set underflow, -> HUNT.
  - Active, x=0, y=0, pix_valid & ~pix_sof: set sof_err, -> HUNT. The pixel is not consumed.
  - Active at any other position with pix_valid & pix_sof: set sof_err, -> ARMED. The pixel is not consumed; error pixel shows FILL_RGB.
- enable=0 or mode=1 from any state -> HUNT with pix_ready = 0.
- Colour bars (mode=1): bar index = floor(8*x/HDISP). Colours in order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is either all-ones or zero.
- Sticky flags clear on clr_status. A set on the same cycle wins.

## Timing
- All video outputs are registered, with one-cycle latency from the counters. A pixel accepted at counter position (x,y) appears on vid_rgb in the next cycle with vid_blank=1.
- vid_rgb = 0 whenever vid_blank = 0. vid_blank = 0 whenever enable = 0.
- Reset values: counters 0, FSM HUNT, vid_hs = vid_vs = ~SYNC_POL, vid_blank 0, vid_rgb 0, frame_start 0, locked 0, underflow 0, sof_err 0.
- Reset asserted mid-frame: all outputs take reset values immediately. No pixel is consumed while reset is asserted.
- The earliest first displayed pixel after lock is the first active pixel of the next frame.
- Counter widths are $clog2(HTOTAL) and $clog2(VTOTAL). x and y subtraction is valid only when active.

## Structure
- Package video_pkg holds the timing struct (hdisp, hfp, hpulse, hbp and vertical equivalents), HTOTAL/VTOTAL helper functions, the FSM state enum (HUNT, ARMED, RUN) and the bar colour lookup function.
- Sub-module video_timing_cnt generates h_cnt, v_cnt, active, the sync pulses and frame_start.
- The FSM and pixel path stay in the top module.

## Test plan
- Small timing (HDISP=8, VDISP=4, porches 2/2/2, 1/1/1), mode=1 -> HS low for 2 cycles every 14-cycle line; bars one pixel wide; frame_start period 14*7 = 98 cycles.
- Stream starting with 5 non-SOF pixels, then a SOF frame -> 5 pixels drained in HUNT, locked rises at frame wrap, and the SOF pixel value appears at the first active output.
- pix_valid dropped for 3 cycles mid-line while locked -> 1 FILL_RGB pixel, underflow=1, locked=0, re-lock on the next SOF.
- SOF injected at x=3, y=1 -> sof_err=1, FSM in ARMED, display resumes at the next frame.
- pixel_rst_n pulsed low mid-frame -> all outputs at reset values within the same cycle.
- SYNC_POL=1, clr_status coincident with an underflow -> sync pulses high; underflow stays 1.
